// File: rtl/free_list_pkg.sv
// Shared sizing constants and pointer types for the rename-stage free list.
package free_list_pkg;

  localparam int unsigned PREG_NUMBER    = 64;
  localparam int unsigned ARCHREG_NUMBER = 32;
  localparam int unsigned FL_SIZE        = PREG_NUMBER - ARCHREG_NUMBER;

  localparam int unsigned PREG_W   = $clog2(PREG_NUMBER);
  localparam int unsigned FL_IDX_W = $clog2(FL_SIZE);
  localparam int unsigned FL_PTR_W = FL_IDX_W + 1;

  typedef logic [FL_PTR_W-1:0] FL_PTR;
  typedef logic [FL_IDX_W-1:0] fl_idx_t;
  typedef logic [PREG_W-1:0]   preg_t;

  localparam FL_PTR FlFull = FL_PTR'(FL_SIZE);

  function automatic FL_PTR pop2(input logic [1:0] v);
    return FL_PTR'(v[0]) + FL_PTR'(v[1]);
  endfunction

endpackage

// File: rtl/free_list.sv
// Two-wide physical-register free list with single-cycle branch rewind to the arch head.
// Optional overflow/underflow checking is built when FREELIST_CHECK_EN is defined.
module free_list
  import free_list_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             dispatch_en_i,
  output logic [1:0][PREG_W-1:0] free_reg_o,
  output logic [1:0]             alloc_grant_o,
  output logic [FL_PTR_W-1:0]    free_cnt_o,
  input  logic [1:0]             retire_en_i,
  input  logic [1:0][PREG_W-1:0] T_old_i,
  input  logic [1:0]             branch_recover_i,
  output logic                   error_o
);

  preg_t   entries_q [FL_SIZE];
  FL_PTR   head_q, head_d;
  FL_PTR   tail_q, tail_d;
  FL_PTR   arch_head_q, arch_head_d;
  FL_PTR   cnt;
  logic    recover;
  logic [1:0] grant;
  logic [1:0] push_ok;
  fl_idx_t head_idx, widx0, widx1;

  logic unused_recover_hi;
  assign unused_recover_hi = branch_recover_i[1];

  assign cnt     = tail_q - head_q;
  assign recover = branch_recover_i[0];

  // Grants use the registered count; same-cycle returns are not bypassed.
  always_comb begin
    grant    = 2'b00;
    grant[0] = reset_n && !recover && dispatch_en_i[0] && (cnt >= FL_PTR'(1));
    grant[1] = grant[0] && dispatch_en_i[1] && (cnt >= FL_PTR'(2));
  end

  assign alloc_grant_o = grant;
  assign free_cnt_o    = cnt;

  assign head_idx      = head_q[FL_IDX_W-1:0];
  assign free_reg_o[0] = entries_q[head_idx];
  assign free_reg_o[1] = entries_q[head_idx + fl_idx_t'(1)];

`ifdef FREELIST_CHECK_EN
  FL_PTR occ0, occ1;
  logic  error_q, error_d;

  // Occupancy excludes slots vacated by this cycle's pops, so a full-rate
  // pop/push pair on a full list is not mistaken for overflow.
  always_comb begin
    occ0       = cnt - pop2(grant);
    push_ok    = 2'b00;
    push_ok[0] = retire_en_i[0] && (occ0 != FlFull);
    occ1       = occ0 + FL_PTR'(push_ok[0]);
    push_ok[1] = retire_en_i[1] && (occ1 != FlFull);
    error_d    = error_q
               | (|(retire_en_i & ~push_ok))
               | (!recover && ((dispatch_en_i[0] && !grant[0]) ||
                               (dispatch_en_i[1] && !grant[1])));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error_o = error_q;
`else
  assign push_ok = retire_en_i;
  assign error_o = 1'b0;
`endif

  always_comb begin
    widx0       = tail_q[FL_IDX_W-1:0];
    widx1       = widx0 + fl_idx_t'(push_ok[0]);
    tail_d      = tail_q + pop2(push_ok);
    arch_head_d = arch_head_q + pop2(retire_en_i);
    // Retirements of the recovery cycle land first, then head snaps to them.
    head_d      = recover ? arch_head_d : head_q + pop2(grant);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        entries_q[i] <= preg_t'(ARCHREG_NUMBER + i);
      end
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= FlFull;
    end else begin
      if (push_ok[0]) entries_q[widx0] <= T_old_i[0];
      if (push_ok[1]) entries_q[widx1] <= T_old_i[1];
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list; a queue model of free and in-flight tags acts as scoreboard.
module tb_free_list;
  import free_list_pkg::*;

  logic                   clk;
  logic                   reset_n;
  logic [1:0]             dispatch_en;
  logic [1:0][PREG_W-1:0] free_reg;
  logic [1:0]             alloc_grant;
  logic [FL_PTR_W-1:0]    free_cnt;
  logic [1:0]             retire_en;
  logic [1:0][PREG_W-1:0] t_old;
  logic [1:0]             recover;
  logic                   error;

  int errors = 0;
  int checks = 0;
  int free_q[$];
  int alloc_q[$];

`ifdef FREELIST_CHECK_EN
  localparam logic ErrAfterUnderflow = 1'b1;
`else
  localparam logic ErrAfterUnderflow = 1'b0;
`endif

  free_list dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .dispatch_en_i    (dispatch_en),
    .free_reg_o       (free_reg),
    .alloc_grant_o    (alloc_grant),
    .free_cnt_o       (free_cnt),
    .retire_en_i      (retire_en),
    .T_old_i          (t_old),
    .branch_recover_i (recover),
    .error_o          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    alloc_q.delete();
    for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
  endtask

  // Drive one cycle's inputs, check combinational outputs against the model,
  // then update the model with this cycle's effects. Called at posedge+1.
  task automatic drive(input logic [1:0] disp, input logic [1:0] ret,
                       input int t0, input int t1, input logic rec);
    logic [1:0] eg;
    int         tag;
    dispatch_en = disp;
    retire_en   = ret;
    t_old[0]    = PREG_W'(t0);
    t_old[1]    = PREG_W'(t1);
    recover     = {1'b0, rec};
    #3;
    chk("free_cnt", free_cnt, free_q.size());
    eg[0] = disp[0] && !rec && (free_q.size() >= 1);
    eg[1] = disp[1] && eg[0] && (free_q.size() >= 2);
    chk("alloc_grant", alloc_grant, eg);
    for (int k = 0; k < 2; k++) begin
      if (eg[k]) begin
        tag = free_q.pop_front();
        chk("free_reg", free_reg[k], tag);
        alloc_q.push_back(tag);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (ret[k]) begin
        if (alloc_q.size() > 0) void'(alloc_q.pop_front());
        free_q.push_back(k == 0 ? t0 : t1);
      end
    end
    if (rec) begin
      free_q = {alloc_q, free_q};
      alloc_q.delete();
    end
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
    dispatch_en = 2'b00;
    retire_en   = 2'b00;
    recover     = 2'b00;
  endtask

  task automatic cycle(input logic [1:0] disp, input logic [1:0] ret,
                       input int t0, input int t1, input logic rec);
    drive(disp, ret, t0, t1, rec);
    fin();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    dispatch_en = 2'b00;
    retire_en = 2'b00;
    recover = 2'b00;
    t_old = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    do_reset();

    // Reset state
    #3;
    chk("rst_cnt", free_cnt, 32);
    chk("rst_err", error, 0);
    chk("rst_grant", alloc_grant, 0);
    fin();

    // First dual allocation
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    chk("first_tag0", free_reg[0], 32);
    chk("first_tag1", free_reg[1], 33);
    chk("first_grant", alloc_grant, 2'b11);
    fin();
    chk("cnt_30", free_cnt, 30);

    // Return 7 (slot 0) and 5 (slot 1)
    cycle(2'b00, 2'b11, 7, 5, 1'b0);
    chk("cnt_32", free_cnt, 32);

    // Drain 34..63, then 7 and 5 come out in order
    for (int i = 0; i < 15; i++) cycle(2'b11, 2'b00, 0, 0, 1'b0);
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    chk("ret_tag0", free_reg[0], 7);
    chk("ret_tag1", free_reg[1], 5);
    fin();
    chk("cnt_empty", free_cnt, 0);

    // Empty list grants nothing
    cycle(2'b01, 2'b00, 0, 0, 1'b0);

    // Single free tag with a dual request
    cycle(2'b00, 2'b01, 9, 0, 1'b0);
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    chk("cnt1_grant", alloc_grant, 2'b01);
    chk("cnt1_tag", free_reg[0], 9);
    fin();
    chk("underflow_err", error, ErrAfterUnderflow);

    // Recovery: allocate 6, retire 2, then recover with one more retirement
    do_reset();
    for (int i = 0; i < 3; i++) cycle(2'b11, 2'b00, 0, 0, 1'b0);
    cycle(2'b00, 2'b11, 1, 2, 1'b0);
    cycle(2'b11, 2'b01, 3, 0, 1'b1);
    chk("recov_cnt", free_cnt, 32);
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    chk("recov_tag0", free_reg[0], 35);
    chk("recov_tag1", free_reg[1], 36);
    fin();

    // Steady two-in/two-out across pointer wrap
    do_reset();
    cycle(2'b11, 2'b00, 0, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(2'b11, 2'b11, (2 * i) % 64, (2 * i + 1) % 64, 1'b0);
      chk("wrap_cnt", free_cnt, 30);
    end
    cycle(2'b00, 2'b11, 10, 11, 1'b0);
    for (int i = 0; i < 16; i++) cycle(2'b11, 2'b00, 0, 0, 1'b0);

    // Reset has priority over recovery
    reset_n     = 1'b0;
    dispatch_en = 2'b11;
    retire_en   = 2'b11;
    recover     = 2'b01;
    @(posedge clk);
    #1;
    reset_n     = 1'b1;
    dispatch_en = 2'b00;
    retire_en   = 2'b00;
    recover     = 2'b00;
    model_reset();
    #3;
    chk("rr_cnt", free_cnt, 32);
    chk("rr_grant", alloc_grant, 0);
    chk("rr_err", error, 0);
    chk("rr_tag0", free_reg[0], 32);
    chk("rr_tag1", free_reg[1], 33);
    fin();
    cycle(2'b11, 2'b00, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
